// File: rtl/mux_n_stream.sv
// N-channel registered stream multiplexer: external-select or round-robin grant, one-deep output register.
// Optional MUX_N_STREAM_PARITY_EN adds out_par, the XOR reduction of the registered word.
module mux_n_stream #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
`ifdef MUX_N_STREAM_PARITY_EN
  output logic            out_par,
`endif
  input  logic            out_ready
);

  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
`ifdef MUX_N_STREAM_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [W-1:0]  ch_data [N];
  logic [W-1:0]  sel_data;
  logic          load_ok;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] scan_idx;
  logic          xfer;

  assign load_ok = !valid_q || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign in_ready[gi] = rst_n && load_ok && grant_vld && (grant_idx == SW'(gi));
    end
  endgenerate

  // Round-robin scans from ptr_q upward, wrapping at N; the first requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!mode) begin
      grant_vld = (int'(sel) < N);
      grant_idx = sel;
    end else begin
      for (int k = 0; k < N; k++) begin
        scan_idx = SW'((int'(ptr_q) + k) % N);
        if (!grant_vld && in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // in_ready is one-hot, so an OR-style pick is enough and never indexes past N.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (in_ready[k]) sel_data = ch_data[k];
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef MUX_N_STREAM_PARITY_EN
    par_d   = par_q;
`endif
    if (xfer) begin
      data_d  = sel_data;
      ch_d    = grant_idx;
      valid_d = 1'b1;
`ifdef MUX_N_STREAM_PARITY_EN
      par_d   = ^sel_data;
`endif
      if (mode) ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_N_STREAM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
`ifdef MUX_N_STREAM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
`ifdef MUX_N_STREAM_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// Scoreboard bench for mux_n_stream: directed stimulus pushes expected words, a monitor pops them on handshake.
module tb_mux_n_stream;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;

  logic        mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
`ifdef MUX_N_STREAM_PARITY_EN
  logic        out_par, out_par3;
`endif

  mux_n_stream #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_N_STREAM_PARITY_EN
    .out_par(out_par),
`endif
    .out_ready(out_ready)
  );

  mux_n_stream #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
`ifdef MUX_N_STREAM_PARITY_EN
    .out_par(out_par3),
`endif
    .out_ready(out_ready3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A word is consumed at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch %0d data %02h expected no word", out_ch, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("word ch %0d data %02h (expected ch %0d data %02h)", out_ch, out_data, mon_e.ch, mon_e.data);
        chk("sb_data", 32'(out_data), 32'(mon_e.data));
        chk("sb_ch", 32'(out_ch), 32'(mon_e.ch));
`ifdef MUX_N_STREAM_PARITY_EN
        chk("sb_par", 32'(out_par), 32'(^mon_e.data));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = 32'h33_A5_21_10;
    mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1; in_valid3 = 3'b000; in_data3 = 24'h0;

    // Reset with all channels requesting
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    // Mode 0, select channel 2
    rst_n = 1'b1; sel = 2'd2;
    #1 chk("m0_in_ready", 32'(in_ready), 32'b0100);
    push(2'd2, 8'hA5);
    step();
    chk("m0_out_valid", 32'(out_valid), 1);
    chk("m0_out_data", 32'(out_data), 32'hA5);
    chk("m0_out_ch", 32'(out_ch), 2);
    in_valid = 4'b0000;
    step();
    chk("m0_drain_valid", 32'(out_valid), 0);

    // Backpressure: hold 0x11 while ch0 presents 0x22
    sel = 2'd0; in_data = 32'h00_00_00_11; in_valid = 4'b0001; out_ready = 1'b0;
    push(2'd0, 8'h11);
    step();
    in_data = 32'h00_00_00_22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_data", 32'(out_data), 32'h11);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    push(2'd0, 8'h22);
    #1 chk("bp_release_ready", 32'(in_ready), 32'b0001);
    step();
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_data", 32'(out_data), 32'h22);
    in_valid = 4'b0000;
    step();
    chk("bp_drain_valid", 32'(out_valid), 0);

    // Round-robin over channels 0,1,3
    mode = 1'b1; in_valid = 4'b1011; in_data = 32'h43_42_41_40;
    #1 chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 8'h40);
      push(2'd1, 8'h41);
      push(2'd3, 8'h43);
    end
    for (int i = 0; i < 6; i++) step();
    chk("rr_last_ch", 32'(out_ch), 3);
    in_valid = 4'b0000;
    step();
    chk("rr_idle_valid", 32'(out_valid), 0);

    // Drain and load on the same edge while switching mode 1 -> 0
    in_valid = 4'b0001; in_data = 32'h63_00_00_50;
    push(2'd0, 8'h50);
    step();
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1000;
    #1 chk("sw_in_ready", 32'(in_ready), 32'b1000);
    push(2'd3, 8'h63);
    step();
    chk("sw_out_valid", 32'(out_valid), 1);
    chk("sw_out_data", 32'(out_data), 32'h63);
    chk("sw_out_ch", 32'(out_ch), 3);
    in_valid = 4'b0000;
    step();
    chk("sw_drain_valid", 32'(out_valid), 0);

    // Parity words, then reset while a word is held
    sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00_00_07_00;
    push(2'd1, 8'h07);
    step();
    chk("par7_data", 32'(out_data), 32'h07);
`ifdef MUX_N_STREAM_PARITY_EN
    chk("par7_par", 32'(out_par), 1);
`endif
    in_data = 32'h00_00_03_00;
    push(2'd1, 8'h03);
    step();
    chk("par3_data", 32'(out_data), 32'h03);
`ifdef MUX_N_STREAM_PARITY_EN
    chk("par3_par", 32'(out_par), 0);
`endif
    rst_n = 1'b0; in_valid = 4'b1111;
    void'(exp_q.pop_front());
    #1 chk("rst2_in_ready", 32'(in_ready), 0);
    step();
    chk("rst2_out_valid", 32'(out_valid), 0);
    chk("rst2_out_data", 32'(out_data), 0);
    chk("rst2_out_ch", 32'(out_ch), 0);
`ifdef MUX_N_STREAM_PARITY_EN
    chk("rst2_out_par", 32'(out_par), 0);
`endif

    // Pointer must be back at 0 after reset
    rst_n = 1'b1; mode = 1'b1; in_data = 32'h83_82_81_80;
    #1 chk("rst2_rr_ready", 32'(in_ready), 32'b0001);
    push(2'd0, 8'h80);
    step();
    in_valid = 4'b0000;
    step();

    // N=3 instance: sel=2 valid, sel=3 out of range
    sel3 = 2'd2; in_valid3 = 3'b111; in_data3 = 24'h77_66_55;
    #1 chk("n3_sel2_ready", 32'(in_ready3), 32'b100);
    step();
    chk("n3_out_valid", 32'(out_valid3), 1);
    chk("n3_out_data", 32'(out_data3), 32'h77);
    chk("n3_out_ch", 32'(out_ch3), 2);
    sel3 = 2'd3;
    #1 chk("n3_sel3_ready", 32'(in_ready3), 0);
    step();
    chk("n3_sel3_valid", 32'(out_valid3), 0);
    chk("n3_hold_data", 32'(out_data3), 32'h77);
    in_valid3 = 3'b000;

    step();
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
